button_debounce_pulse: RTL and testbench
========================================

// Module: button_debounce_pulse
// PURPOSE
//   Upstream conditioning stage for the 3-bit up counter. Takes a raw, asynchronous,
//   bouncing pushbutton and synchronises it to clk. Debounces it and emits exactly one
//   single-cycle btn_pulse per genuine press; btn_pulse drives the counter's increment.
//   Also provides the debounced level and a one-cycle release pulse.
// PARAMETERS
//   STABLE_CYCLES  default 4   consecutive synchronised samples required to accept a change (>=2)
//   CNT_W          default 3   stability-counter width; must satisfy 2**CNT_W >= STABLE_CYCLES
// PORTS
//   clk          input   1   single clock, rising-edge
//   rst_n        input   1   asynchronous, active-low reset
//   btn_in       input   1   raw button, asynchronous to clk, may bounce
//   btn_level    output  1   debounced button level (1 = pressed)
//   btn_pulse    output  1   one-cycle high on each accepted press
//   btn_release  output  1   one-cycle high on each accepted release
// BEHAVIOUR
//   - Reset (rst_n=0, async): sync flops=0, state=IDLE, cnt=0, btn_level=0, btn_pulse=0, btn_release=0.
//     Deassertion mid-bounce restarts qualification from IDLE; no pulse is emitted on reset exit.
//   - Synchroniser: 2 flops, btn_in -> s1 -> s2 (=sync). Only sync feeds the FSM.
//   - FSM (4 states):
//     IDLE:         sync=1 -> PRESS_WAIT, cnt<=0.
//     PRESS_WAIT:   sync=0 -> IDLE (bounce rejected, no output).
//                   sync=1 & cnt<STABLE_CYCLES-1 -> cnt<=cnt+1.
//                   sync=1 & cnt==STABLE_CYCLES-1 -> PRESSED, btn_pulse<=1, btn_level<=1.
//     PRESSED:      sync=0 -> RELEASE_WAIT, cnt<=0.
//     RELEASE_WAIT: sync=1 -> PRESSED (bounce rejected, no new btn_pulse).
//                   sync=0 & cnt<STABLE_CYCLES-1 -> cnt<=cnt+1.
//                   sync=0 & cnt==STABLE_CYCLES-1 -> IDLE, btn_release<=1, btn_level<=0.
//   - All outputs are registered. btn_pulse and btn_release are high for exactly one cycle and
//     never in the same cycle. btn_level changes in the same cycle its pulse rises.
//   - Latency: btn_in rises and stays high at edge E0. btn_pulse is high in the cycle after edge
//     E0+STABLE_CYCLES+2. Release latency is symmetric.
//   - Any glitch shorter than STABLE_CYCLES synchronised samples produces no output.
//   - cnt never wraps. It is cleared on every state entry and bounded by the compare.
//   - A held button produces exactly one btn_pulse, regardless of hold length.
//   - Illegal or unused state encodings recover to IDLE on the next edge.
// STRUCTURE
//   - Shared package/include debounce_defs: state encodings ST_IDLE=2'd0, ST_PRESS_WAIT=2'd1,
//     ST_PRESSED=2'd2, ST_RELEASE_WAIT=2'd3.
//   - Sub-module sync_2ff (1-bit, clk, rst_n, d, q), reusable for other async inputs.
//   - Top level: sync_2ff instance, state register, stability counter, registered outputs.
// TESTING (clk period 10 ns, STABLE_CYCLES=4; E0 = first edge sampling btn_in=1)
//   1. Reset: rst_n=0 with btn_in=1 -> all outputs 0. Release rst_n, btn_in held -> one
//      btn_pulse after E0+6, btn_level=1.
//   2. Clean press: btn_in 0->1, held 200 ns -> exactly one btn_pulse in the cycle after E0+6;
//      btn_level=1 from the same cycle.
//   3. Bounce: btn_in toggles 1,0,1,0 every 10 ns, then stays 1 -> no pulse during toggling;
//      one pulse 7 edges after the final rise.
//   4. Release bounce: from PRESSED, btn_in 0 for 2 cycles then 1 -> no btn_release,
//      btn_level stays 1, no extra btn_pulse.
//   5. Clean release: btn_in 1->0, held -> one btn_release 7 edges later, btn_level=0;
//      btn_pulse never high.
//   6. Mid-op reset: rst_n pulsed low during PRESS_WAIT -> outputs 0 immediately (async).
//      After release, qualification restarts and yields one pulse.
//   Integration: feed btn_pulse into the counter's increment; 5 clean presses -> count=3'b101.

Source files
------------

// File: rtl/debounce_defs.sv
// FSM state encodings shared by the debounce logic and anything that decodes its state.
package debounce_defs;
  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;
endmodule

// File: rtl/button_debounce_pulse.sv
// Synchronises and debounces a raw pushbutton; emits a debounced level plus
// one-cycle press and release pulses.
module button_debounce_pulse
  import debounce_defs::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_release
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             w_sync;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_pulse;
  logic             r_release;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (w_sync)
  );

  // Pulses default low each cycle so they can only ever last one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_pulse   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_pulse   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_sync) begin
            r_state <= ST_PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!w_sync) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_PRESSED;
            r_pulse <= 1'b1;
            r_level <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!w_sync) begin
            r_state <= ST_RELEASE_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (w_sync) begin
            r_state <= ST_PRESSED;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= ST_IDLE;
            r_release <= 1'b1;
            r_level   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level   = r_level;
  assign btn_pulse   = r_pulse;
  assign btn_release = r_release;
endmodule

// File: tb/tb_button_debounce_pulse.sv
// Randomised and directed bench for button_debounce_pulse with a run-length reference model.
module tb_button_debounce_pulse;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_in = 1'b1;
  logic btn_level, btn_pulse, btn_release;

  button_debounce_pulse #(.STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_pulse   (btn_pulse),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;

  typedef struct { bit press; int cyc; } ev_t;
  ev_t q[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int n_pulse = 0, n_rel = 0;
  int last_pulse_cyc = -1, last_rel_cyc = -1;
  logic [2:0] cnt3 = 3'd0;

  // reference model state
  bit m_p1, m_p2, m_level;
  int m_run;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: raw input reaches the decision logic two edges late; the debounced level
  // flips once the delayed input has differed from it for STABLE+1 consecutive samples.
  initial begin
    bit sv;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_p1 = 0; m_p2 = 0; m_level = 0; m_run = 0;
        q.delete();
      end else begin
        cyc++;
        sv = m_p2;
        m_p2 = m_p1;
        m_p1 = btn_in;
        if (sv != m_level) begin
          m_run++;
          if (m_run == STABLE + 1) begin
            m_level = sv;
            m_run = 0;
            q.push_back('{press: sv, cyc: cyc});
          end
        end else begin
          m_run = 0;
        end
      end
    end
  end

  // Monitor: compares every active cycle against the queued expectations.
  initial begin
    bit ep, er;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        ep = 0; er = 0;
        if (q.size() > 0 && q[0].cyc == cyc) begin
          ep = q[0].press;
          er = !q[0].press;
          void'(q.pop_front());
        end
        chk("pulse", int'(btn_pulse), int'(ep));
        chk("release", int'(btn_release), int'(er));
        chk("level", int'(btn_level), int'(m_level));
        if (btn_pulse) begin n_pulse++; last_pulse_cyc = cyc; cnt3 = cnt3 + 3'd1; end
        if (btn_release) begin n_rel++; last_rel_cyc = cyc; end
      end
    end
  end

  task automatic drive(input bit v, input int n);
    btn_in = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c, np, nr;
    // reset with button held
    repeat (3) @(negedge clk);
    chk("rst_level", int'(btn_level), 0);
    chk("rst_pulse", int'(btn_pulse), 0);
    chk("rst_release", int'(btn_release), 0);
    c = cyc; np = n_pulse;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rstexit_pulse_cyc", last_pulse_cyc, c + 7);
    chk("rstexit_npulse", n_pulse - np, 1);
    chk("rstexit_level", int'(btn_level), 1);
    drive(0, 20);

    // clean press, held 200 ns
    c = cyc; np = n_pulse;
    drive(1, 20);
    chk("press_cyc", last_pulse_cyc, c + 7);
    chk("press_npulse", n_pulse - np, 1);
    chk("press_level", int'(btn_level), 1);
    drive(0, 20);

    // bounce then settle high
    np = n_pulse;
    drive(1, 1); drive(0, 1); drive(1, 1); drive(0, 1);
    chk("bounce_nopulse", n_pulse - np, 0);
    c = cyc;
    drive(1, 20);
    chk("bounce_cyc", last_pulse_cyc, c + 7);
    chk("bounce_npulse", n_pulse - np, 1);

    // release bounce from pressed
    np = n_pulse; nr = n_rel;
    drive(0, 2);
    drive(1, 15);
    chk("relbounce_nrel", n_rel - nr, 0);
    chk("relbounce_npulse", n_pulse - np, 0);
    chk("relbounce_level", int'(btn_level), 1);

    // clean release
    c = cyc; np = n_pulse;
    drive(0, 20);
    chk("release_cyc", last_rel_cyc, c + 7);
    chk("release_npulse", n_pulse - np, 0);
    chk("release_level", int'(btn_level), 0);

    // async reset during PRESS_WAIT
    drive(1, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_level", int'(btn_level), 0);
    chk("midrst_pulse", int'(btn_pulse), 0);
    @(negedge clk);
    c = cyc; np = n_pulse;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_restart_cyc", last_pulse_cyc, c + 7);
    chk("midrst_npulse", n_pulse - np, 1);
    // async reset while pressed clears the level without waiting for a clock
    #2 rst_n = 1'b0;
    #1;
    chk("prst_level", int'(btn_level), 0);
    btn_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // randomised runs
    for (int i = 0; i < 200; i++) drive(1'($urandom_range(0, 1)), $urandom_range(1, 12));
    drive(0, 20);

    // integration: five clean presses increment a 3-bit counter
    cnt3 = 3'd0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 12);
      drive(0, 12);
    end
    chk("count_after_5", int'(cnt3), 5);
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
